// File: rtl/se_pkg.sv
// se_pkg: shared widths, source ids and slot state encoding for the sign-extension arbiter
package se_pkg;
    localparam int IN_W = 9;
    localparam int OUT_W = 16;
    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } st_e;
endpackage

// File: rtl/se_share_arbiter_se9x16.sv
// se9x16: combinational 9-to-16-bit two's complement sign extension
// Ports: imm_i immediate in, ext_o sign-extended result out.
module se9x16
    import se_pkg::*;
(
    input  logic [IN_W-1:0]  imm_i,
    output logic [OUT_W-1:0] ext_o
);
    assign ext_o = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
endmodule

// File: rtl/se_share_arbiter.sv
// se_share_arbiter: round-robin arbiter sharing one SE9x16 between two immediate requesters
// Ports: clk/rst (async, active high); req0_*/req1_* valid/imm/ready requester handshakes;
//        out_valid/out_data/out_src/out_ready single registered result slot; busy mirrors out_valid;
//        cnt_clr synchronously clears conflict_cnt, the saturating count of stalled-request cycles.
module se_share_arbiter
    import se_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [IN_W-1:0]  req0_imm,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [IN_W-1:0]  req1_imm,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] conflict_cnt
);
    st_e              st_q;
    logic             ptr_q;
    logic             src_q;
    logic [OUT_W-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [OUT_W-1:0] ext;
    logic             slot_free;
    logic             g0;
    logic             g1;
    logic             stall;

    assign out_valid = st_q == ST_FULL;
    assign busy = out_valid;
    assign out_data = data_q;
    assign out_src = src_q;
    assign conflict_cnt = cnt_q;
    // A draining slot can accept a new result in the same cycle, so there is no bubble.
    assign slot_free = !out_valid | out_ready;
    // ptr only breaks ties; a lone requester wins regardless of it.
    assign g0 = slot_free & req0_valid & (!req1_valid | ptr_q == SRC_REQ0);
    assign g1 = slot_free & req1_valid & (!req0_valid | ptr_q == SRC_REQ1);
    assign req0_ready = g0;
    assign req1_ready = g1;
    assign stall = (req0_valid & !g0) | (req1_valid & !g1);

    se9x16 u_se (
        .imm_i(g1 ? req1_imm : req0_imm),
        .ext_o(ext)
    );

    always_comb begin
        cnt_d = cnt_clr ? '0 : (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= ST_EMPTY;
            ptr_q <= SRC_REQ0;
            src_q <= SRC_REQ0;
            data_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (g0 | g1) begin
                st_q <= ST_FULL;
                data_q <= ext;
                src_q <= g1 ? SRC_REQ1 : SRC_REQ0;
                ptr_q <= g1 ? SRC_REQ0 : SRC_REQ1;
            end else if (out_ready) begin
                st_q <= ST_EMPTY;
            end
        end
    end
endmodule

// File: doc/se_share_arbiter.md
Name: se_share_arbiter

Overview:
- Arbitrates one shared 9-to-16-bit sign-extension unit (SE9x16) between two immediate requesters: req0 is decode load-immediate, req1 is branch-offset fetch.
- Round-robin grant with valid/ready handshakes on both sides.
- Single registered output slot, so sustained throughput is one extension per cycle.
- Sits between the decode/fetch stages and the ALU operand mux of the calculator datapath.

Parameters:
- IN_W, 9, immediate width; fixed to match SE9x16.
- OUT_W, 16, extended width; fixed to match SE9x16.
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an immediate.
- req0_imm  in  IN_W  requester 0 immediate, two's complement.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_valid  in  1  requester 1 has an immediate.
- req1_imm  in  IN_W  requester 1 immediate.
- req1_ready  out  1  requester 1 transfer accepted this cycle.
- out_valid  out  1  out_data/out_src hold a result.
- out_data  out  OUT_W  sign-extended immediate.
- out_src  out  1  source of the result: 0 = req0, 1 = req1.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  equals out_valid.
- cnt_clr  in  1  synchronous clear of conflict_cnt.
- conflict_cnt  out  CNT_W  saturating count of stalled-request cycles.

Behaviour:
- Reset (async, while rst is high):
  - out_valid=0, out_data=0, out_src=0, conflict_cnt=0.
  - Priority pointer ptr=0, so req0 is favoured first.
- Slot free condition: slot_free = !out_valid | out_ready.
- Grant (combinational):
  - If slot_free and only one reqN_valid is high, grant that requester.
  - If slot_free and both are valid, grant the requester named by ptr.
  - If no slot is free, there is no grant.
- Ready signals:
  - reqN_ready = grant to N. At most one ready is high per cycle.
  - reqN_ready depends on the other requester's valid. It is never high when the slot is not free.
- Transfer on reqN_valid & reqN_ready at edge T:
  - out_data <= SE9x16(reqN_imm), out_src <= N, out_valid <= 1, visible at T+1.
  - Latency is 1 cycle.
- Drain:
  - out_valid & out_ready with no new grant gives out_valid <= 0.
  - out_data and out_src keep their last values.
- Drain and grant in the same cycle: the slot reloads with the new result and out_valid stays 1. There is no bubble.
- Stall: while out_valid & !out_ready, out_data and out_src are held stable and both readies are 0.
- Pointer: after any grant, ptr <= ~granted_index. With no grant, ptr holds.
- Requester contract: requesters must hold valid and imm stable until ready. The arbiter does not check this.
- conflict_cnt update per cycle:
  - cnt_clr=1 gives 0; this has priority over increment.
  - Otherwise, increment by 1 if any reqN_valid is high and that requester is not granted. Both stalled still counts as +1.
  - Saturates at 2^CNT_W-1. No wrap.
- State machine, two states:
  - EMPTY (out_valid=0) to FULL on grant.
  - FULL to EMPTY on out_ready with no grant.
  - FULL to FULL otherwise.
- Reset mid-transfer: an in-flight result is discarded with no output pulse. ptr returns to 0.
- Arithmetic: out_data[15:9] = imm[8]; out_data[8:0] = imm. Pure replication, no overflow case.

Decomposition:
- Shared package se_pkg:
  - IN_W=9, OUT_W=16.
  - SRC_REQ0=1'b0, SRC_REQ1=1'b1.
  - State encodings ST_EMPTY=1'b0, ST_FULL=1'b1.
- One sub-module: the existing SE9x16, instantiated once on the muxed granted immediate.
- Arbitration, output slot and counter live in se_share_arbiter.

Test Plan:
- Reset, then req0 only with imm=9'b101100110 and out_ready=1 -> req0_ready=1 that cycle; next cycle out_valid=1, out_data=16'hFF66, out_src=0.
- req1 only with imm=9'b001011110 -> after 1 cycle out_data=16'h005E, out_src=1. Also apply 9'h0FF -> 16'h00FF and 9'h100 -> 16'hFF00.
- Both valid for 4 consecutive transfers with out_ready=1 -> grants alternate req0, req1, req0, req1; out_valid stays 1 with no bubbles.
- Stall with out_valid=1, out_ready=0 for 3 cycles and both reqs valid -> out_data stable, both readies 0, conflict_cnt=3. Raise out_ready -> same-cycle drain+grant.
- conflict_cnt with CNT_W=2, 5 stalled cycles -> value 3 (saturated). Assert cnt_clr together with a stall -> 0.
- Assert rst asynchronously mid-FULL (between clock edges) -> out_valid=0 immediately. After release, both valid -> req0 granted first.
